// File: rtl/snitch_lsu_tcdm_adapter.sv
// LSU-to-TCDM bank adapter: credit-limited issue, fixed-latency response pipe, fall-through response FIFO.
// Define SNITCH_TCDM_ADAPTER_ERR_EN to store mem_err_i per response and forward it on in_perror_o.
module snitch_lsu_tcdm_adapter #(
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned MemLatency     = 1,
    localparam int unsigned IdWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        in_qaddr_i,
    input  logic               in_qwrite_i,
    input  logic [3:0]         in_qamo_i,
    input  logic [31:0]        in_qdata_i,
    input  logic [3:0]         in_qstrb_i,
    input  logic [IdWidth-1:0] in_qid_i,
    input  logic               in_qvalid_i,
    output logic               in_qready_o,
    output logic [31:0]        in_pdata_o,
    output logic               in_perror_o,
    output logic [IdWidth-1:0] in_pid_o,
    output logic               in_pvalid_o,
    input  logic               in_pready_i,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic [31:0]        mem_addr_o,
    output logic               mem_we_o,
    output logic [3:0]         mem_amo_o,
    output logic [31:0]        mem_wdata_o,
    output logic [3:0]         mem_be_o,
    input  logic [31:0]        mem_rdata_i,
    input  logic               mem_err_i
);
    localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
    localparam int unsigned PtrWidth = IdWidth;
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumOutstanding);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(NumOutstanding - 1)) ? '0 : ptr + 1'b1;
    endfunction

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] usage_q, usage_d;
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [MemLatency-1:0] pipe_vld_q;
    logic [IdWidth-1:0]    pipe_id_q [MemLatency];
    logic [31:0]           data_q [NumOutstanding];
    logic [IdWidth-1:0]    id_q   [NumOutstanding];

    logic can_issue, accept, push, pop, empty, store, deq;

    assign mem_addr_o  = in_qaddr_i;
    assign mem_we_o    = in_qwrite_i;
    assign mem_amo_o   = in_qamo_i;
    assign mem_wdata_o = in_qdata_i;
    assign mem_be_o    = in_qstrb_i;

    assign can_issue   = cnt_q < MaxCnt;
    assign mem_req_o   = in_qvalid_i && can_issue && !rst_i;
    assign in_qready_o = mem_gnt_i && can_issue && !rst_i;
    assign accept      = in_qvalid_i && in_qready_o;

    // Response side: pipe exit feeds the FIFO, bypassing storage when it is empty.
    assign push        = pipe_vld_q[MemLatency-1] && !rst_i;
    assign empty       = (usage_q == '0);
    assign in_pvalid_o = (!empty || push) && !rst_i;
    assign pop         = in_pvalid_o && in_pready_i;
    assign store       = push && !(empty && pop);
    assign deq         = pop && !empty;
    assign in_pdata_o  = empty ? mem_rdata_i : data_q[rd_ptr_q];
    assign in_pid_o    = empty ? pipe_id_q[MemLatency-1] : id_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) cnt_d = cnt_q + 1'b1;
        else if (!accept && pop) cnt_d = cnt_q - 1'b1;
        usage_d = usage_q;
        if (store && !deq) usage_d = usage_q + 1'b1;
        else if (!store && deq) usage_d = usage_q - 1'b1;
        wr_ptr_d = store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            usage_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pipe_vld_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            usage_q  <= usage_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = MemLatency - 1; i > 0; i--) pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_vld_q[0] <= accept;
        end
    end

    // Payload storage carries no reset; validity is tracked by the control state above.
    always_ff @(posedge clk_i) begin
        for (int i = MemLatency - 1; i > 0; i--) pipe_id_q[i] <= pipe_id_q[i-1];
        pipe_id_q[0] <= in_qid_i;
        if (store) begin
            data_q[wr_ptr_q] <= mem_rdata_i;
            id_q[wr_ptr_q]   <= pipe_id_q[MemLatency-1];
        end
    end

`ifdef SNITCH_TCDM_ADAPTER_ERR_EN
    logic err_q [NumOutstanding];

    assign in_perror_o = empty ? mem_err_i : err_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (store) err_q[wr_ptr_q] <= mem_err_i;
    end
`else
    logic unused_err;

    assign unused_err  = mem_err_i;
    assign in_perror_o = 1'b0;
`endif

endmodule

// File: tb/tb_snitch_lsu_tcdm_adapter.sv
// Scoreboard bench for snitch_lsu_tcdm_adapter with a fixed-latency bank model (default parameters).
module tb_snitch_lsu_tcdm_adapter;
    localparam int NumOut = 4;
    localparam int MemLat = 1;
    localparam int IdW    = 2;
`ifdef SNITCH_TCDM_ADAPTER_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i;
    logic [31:0]    in_qaddr_i;
    logic           in_qwrite_i;
    logic [3:0]     in_qamo_i;
    logic [31:0]    in_qdata_i;
    logic [3:0]     in_qstrb_i;
    logic [IdW-1:0] in_qid_i;
    logic           in_qvalid_i;
    logic           in_qready_o;
    logic [31:0]    in_pdata_o;
    logic           in_perror_o;
    logic [IdW-1:0] in_pid_o;
    logic           in_pvalid_o;
    logic           in_pready_i;
    logic           mem_req_o;
    logic           mem_gnt_i;
    logic [31:0]    mem_addr_o;
    logic           mem_we_o;
    logic [3:0]     mem_amo_o;
    logic [31:0]    mem_wdata_o;
    logic [3:0]     mem_be_o;
    logic [31:0]    mem_rdata_i = 32'h0;
    logic           mem_err_i = 1'b0;

    snitch_lsu_tcdm_adapter #(.NumOutstanding(NumOut), .MemLatency(MemLat)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_qaddr_i(in_qaddr_i), .in_qwrite_i(in_qwrite_i), .in_qamo_i(in_qamo_i),
        .in_qdata_i(in_qdata_i), .in_qstrb_i(in_qstrb_i), .in_qid_i(in_qid_i),
        .in_qvalid_i(in_qvalid_i), .in_qready_o(in_qready_o),
        .in_pdata_o(in_pdata_o), .in_perror_o(in_perror_o), .in_pid_o(in_pid_o),
        .in_pvalid_o(in_pvalid_o), .in_pready_i(in_pready_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_amo_o(mem_amo_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [31:0]    data;
        logic           err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          resp_cnt = 0;
    logic [31:0] next_rdata = 32'h0;
    logic        next_err = 1'b0;
    bit          mp_vld [MemLat];
    logic [31:0] mp_data [MemLat];
    logic        mp_err [MemLat];

    // Bank model: data chosen at grant time returns exactly MemLat cycles later.
    always @(negedge clk) begin
        bit          g;
        logic [31:0] d;
        logic        e;
        g = mem_req_o && mem_gnt_i;
        d = next_rdata;
        e = next_err;
        @(posedge clk);
        #1;
        for (int i = MemLat - 1; i > 0; i--) begin
            mp_vld[i]  = mp_vld[i-1];
            mp_data[i] = mp_data[i-1];
            mp_err[i]  = mp_err[i-1];
        end
        mp_vld[0]   = g;
        mp_data[0]  = d;
        mp_err[0]   = e;
        mem_rdata_i = mp_vld[MemLat-1] ? mp_data[MemLat-1] : 32'h0BAD_0BAD;
        mem_err_i   = mp_vld[MemLat-1] ? mp_err[MemLat-1] : 1'b1;
    end

    // Scoreboard: expected response queued on accept, compared on every response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            sb.delete();
        end else begin
            if (in_pvalid_o && in_pready_i) begin
                resp_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got pid=%0d data=%h, expected no response", in_pid_o, in_pdata_o);
                end else begin
                    e = sb.pop_front();
                    if ({in_pid_o, in_pdata_o, in_perror_o} !== {e.id, e.data, e.err}) begin
                        errors++;
                        $display("FAIL resp_payload: got id=%0d data=%h err=%b, expected id=%0d data=%h err=%b",
                                 in_pid_o, in_pdata_o, in_perror_o, e.id, e.data, e.err);
                    end
                end
            end
            if (in_qvalid_i && in_qready_o) begin
                e.id   = in_qid_i;
                e.data = next_rdata;
                e.err  = ErrEn ? next_err : 1'b0;
                sb.push_back(e);
            end
            if (dut.push && dut.usage_q == NumOut) begin
                errors++;
                $display("FAIL fifo_overflow: got push with usage=%0d, expected usage < %0d", dut.usage_q, NumOut);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic [IdW-1:0] id, input logic [31:0] rdata);
        in_qaddr_i  = addr;
        in_qid_i    = id;
        in_qwrite_i = 1'b0;
        in_qstrb_i  = 4'hF;
        in_qdata_i  = ~addr;
        next_rdata  = rdata;
        in_qvalid_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_qvalid_i = 1'b1; mem_gnt_i = 1'b1; in_pready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); end
            checks++; if (in_qready_o !== 1'b0) begin errors++; $display("FAIL reset_qready: got %b expected 0", in_qready_o); end
            checks++; if (in_pvalid_o !== 1'b0) begin errors++; $display("FAIL reset_pvalid: got %b expected 0", in_pvalid_o); end
        end
        step();
        rst_i = 1'b0; in_qvalid_i = 1'b0;
        @(negedge clk);
        checks++; if (dut.cnt_q !== 0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
    endtask

    task automatic test_single_read();
        step();
        in_pready_i = 1'b1; mem_gnt_i = 1'b1;
        set_req(32'h0000_0100, 2'd2, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (in_qready_o !== 1'b1) begin errors++; $display("FAIL read_qready: got %b expected 1", in_qready_o); end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL read_mem_req: got %b expected 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL read_addr: got %h expected 00000100", mem_addr_o); end
        step();
        in_qvalid_i = 1'b0;
        @(negedge clk);
        checks++; if (in_pvalid_o !== 1'b1) begin errors++; $display("FAIL read_pvalid: got %b expected 1", in_pvalid_o); end
        checks++; if (in_pdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_pdata: got %h expected deadbeef", in_pdata_o); end
        checks++; if (in_pid_o !== 2'd2) begin errors++; $display("FAIL read_pid: got %0d expected 2", in_pid_o); end
        step();
        @(negedge clk);
        checks++; if (dut.cnt_q !== 0) begin errors++; $display("FAIL read_cnt: got %0d expected 0", dut.cnt_q); end
    endtask

    task automatic test_fill_drain();
        step();
        in_pready_i = 1'b0; mem_gnt_i = 1'b1;
        for (int k = 0; k < NumOut; k++) begin
            set_req(32'h200 + 32'(k), IdW'(k), 32'h1000 + 32'(k));
            @(negedge clk);
            checks++; if (in_qready_o !== 1'b1) begin errors++; $display("FAIL fill_qready_%0d: got %b expected 1", k, in_qready_o); end
            step();
        end
        set_req(32'h2FF, 2'd0, 32'h5555_0000);
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_qready_o !== 1'b0) begin errors++; $display("FAIL full_qready: got %b expected 0", in_qready_o); end
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL full_mem_req: got %b expected 0", mem_req_o); end
            step();
        end
        in_qvalid_i = 1'b0; in_pready_i = 1'b1;
        for (int k = 0; k < NumOut; k++) begin
            @(negedge clk);
            checks++;
            if (in_pvalid_o !== 1'b1 || in_pid_o !== IdW'(k)) begin
                errors++; $display("FAIL drain_order_%0d: got pvalid=%b pid=%0d expected pvalid=1 pid=%0d", k, in_pvalid_o, in_pid_o, k);
            end
            step();
        end
        set_req(32'h300, 2'd3, 32'h7777_0003);
        @(negedge clk);
        checks++; if (in_qready_o !== 1'b1) begin errors++; $display("FAIL after_drain_qready: got %b expected 1", in_qready_o); end
        step();
        in_qvalid_i = 1'b0;
        step(); step();
    endtask

    task automatic test_write();
        int r0;
        r0 = resp_cnt;
        set_req(32'h0000_0400, 2'd1, 32'h0000_0000);
        in_qwrite_i = 1'b1; in_qstrb_i = 4'b0011; in_qdata_i = 32'hCAFE_F00D; in_qamo_i = 4'h0;
        @(negedge clk);
        checks++; if (mem_be_o !== 4'b0011) begin errors++; $display("FAIL write_be: got %b expected 0011", mem_be_o); end
        checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL write_we: got %b expected 1", mem_we_o); end
        checks++; if (mem_wdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_wdata: got %h expected cafef00d", mem_wdata_o); end
        step();
        in_qvalid_i = 1'b0; in_qwrite_i = 1'b0;
        repeat (4) step();
        checks++; if (resp_cnt - r0 !== 1) begin errors++; $display("FAIL write_resp_count: got %0d expected 1", resp_cnt - r0); end
    endtask

    task automatic test_no_grant();
        int r0;
        r0 = resp_cnt;
        mem_gnt_i = 1'b0;
        set_req(32'h500, 2'd1, 32'h0000_0500);
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_qready_o !== 1'b0) begin errors++; $display("FAIL nogrant_qready: got %b expected 0", in_qready_o); end
            checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL nogrant_mem_req: got %b expected 1", mem_req_o); end
            step();
        end
        in_qvalid_i = 1'b0; mem_gnt_i = 1'b1;
        step(); step();
        checks++; if (dut.cnt_q !== 0) begin errors++; $display("FAIL nogrant_cnt: got %0d expected 0", dut.cnt_q); end
        checks++; if (resp_cnt !== r0) begin errors++; $display("FAIL nogrant_resp: got %0d expected %0d", resp_cnt, r0); end
    endtask

    task automatic test_accept_pop();
        in_pready_i = 1'b0;
        set_req(32'h600, 2'd0, 32'h6000_0000); step();
        set_req(32'h601, 2'd1, 32'h6000_0001); step();
        in_qvalid_i = 1'b0;
        step();
        in_pready_i = 1'b1;
        set_req(32'h602, 2'd2, 32'h6000_0002);
        @(negedge clk);
        checks++;
        if (in_qready_o !== 1'b1 || in_pvalid_o !== 1'b1 || dut.cnt_q !== 2) begin
            errors++; $display("FAIL accpop_setup: got qready=%b pvalid=%b cnt=%0d expected 1 1 2", in_qready_o, in_pvalid_o, dut.cnt_q);
        end
        step();
        in_qvalid_i = 1'b0; in_pready_i = 1'b0;
        @(negedge clk);
        checks++; if (dut.cnt_q !== 2) begin errors++; $display("FAIL accpop_cnt: got %0d expected 2", dut.cnt_q); end
        in_pready_i = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_error();
        in_pready_i = 1'b1;
        set_req(32'h700, 2'd3, 32'h0E0E_0E0E);
        next_err = 1'b1;
        step();
        in_qvalid_i = 1'b0; next_err = 1'b0;
        @(negedge clk);
        checks++;
        if (in_pvalid_o !== 1'b1 || in_perror_o !== ErrEn) begin
            errors++; $display("FAIL error_bit: got pvalid=%b perror=%b expected pvalid=1 perror=%b", in_pvalid_o, in_perror_o, ErrEn);
        end
        step(); step();
    endtask

    task automatic test_reset_inflight();
        in_pready_i = 1'b0;
        set_req(32'h800, 2'd1, 32'h8000_0001); step();
        set_req(32'h801, 2'd2, 32'h8000_0002); step();
        in_qvalid_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; in_pready_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++; if (in_pvalid_o !== 1'b0) begin errors++; $display("FAIL rst_inflight_pvalid: got %b expected 0", in_pvalid_o); end
            step();
        end
        checks++; if (dut.cnt_q !== 0) begin errors++; $display("FAIL rst_inflight_cnt: got %0d expected 0", dut.cnt_q); end
    endtask

    task automatic test_back_to_back();
        in_pready_i = 1'b1; mem_gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_req(32'h900 + 32'(k), IdW'(k), $urandom);
            @(negedge clk);
            checks++; if (in_qready_o !== 1'b1) begin errors++; $display("FAIL b2b_qready_%0d: got %b expected 1", k, in_qready_o); end
            step();
        end
        in_qvalid_i = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_random();
        int budget;
        for (int k = 0; k < 300; k++) begin
            set_req($urandom, IdW'($urandom), $urandom);
            in_qwrite_i = 1'(($urandom % 2));
            in_qvalid_i = ($urandom % 4) != 0;
            mem_gnt_i   = ($urandom % 3) != 0;
            in_pready_i = ($urandom % 3) != 0;
            next_err    = 1'(($urandom % 2));
            step();
        end
        in_qvalid_i = 1'b0; in_pready_i = 1'b1; next_err = 1'b0;
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            step();
            budget++;
        end
        step();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending expected 0", sb.size()); end
        checks++; if (dut.cnt_q !== 0) begin errors++; $display("FAIL random_cnt: got %0d expected 0", dut.cnt_q); end
    endtask

    initial begin
        rst_i = 1'b1; in_qaddr_i = '0; in_qwrite_i = 1'b0; in_qamo_i = '0; in_qdata_i = '0;
        in_qstrb_i = '0; in_qid_i = '0; in_qvalid_i = 1'b0; in_pready_i = 1'b0; mem_gnt_i = 1'b0;
        test_reset();
        test_single_read();
        test_fill_drain();
        test_write();
        test_no_grant();
        test_accept_pop();
        test_error();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
